mem_req_ctrl: RTL and testbench



---
 rtl/mem_req_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Data-memory controller: one outstanding valid/ready request, fixed access latency,
// little-endian byte lanes, sign/zero-extended loads and error responses.
module mem_req_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [1:0]        dbg_state
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // Handshake rule for both channels: a transfer happens on a rising clk edge
    // where valid and ready are both 1; the producer holds its payload until then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              accept, enter_resp;

    logic              write_q, unsigned_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              a_write, a_unsigned, a_err;
    logic [1:0]        a_size, lane;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word, rd_shift, load_data, wdata_sh;
    logic [3:0]        be;

    logic [31:0]       mem [DEPTH_WORDS];

    assign req_ready  = rst_n && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign dbg_state  = state;
    assign accept     = req_valid && req_ready;

    always_comb begin
        state_nxt  = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the acceptance edge, before capture.
    always_comb begin
        if (state == IDLE) begin
            a_write    = req_write;
            a_size     = req_size;
            a_unsigned = req_unsigned;
            a_addr     = req_addr;
            a_wdata    = req_wdata;
        end else begin
            a_write    = write_q;
            a_size     = size_q;
            a_unsigned = unsigned_q;
            a_addr     = addr_q;
            a_wdata    = wdata_q;
        end
    end

    assign idx      = a_addr[IDX_W+1:2];
    assign lane     = a_addr[1:0];
    assign a_err    = (a_size == 2'b11)
                   || (a_size == 2'b10 && a_addr[0])
                   || (a_size == 2'b00 && a_addr[1:0] != 2'b00)
                   || (|a_addr[ADDR_W-1:IDX_W+2]);
    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};
    assign wdata_sh = a_wdata << {lane, 3'b000};

    always_comb begin
        load_data = rd_word;
        be        = 4'b1111;
        case (a_size)
            2'b01: begin
                be        = 4'b0001 << lane;
                load_data = a_unsigned ? {24'h0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
            end
            2'b10: begin
                be        = 4'b0011 << lane;
                load_data = a_unsigned ? {16'h0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
            end
            default: begin
                be        = 4'b1111;
                load_data = rd_word;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                size_q     <= req_size;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                cnt        <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_err   <= a_err;
                resp_rdata <= (a_err || a_write) ? 32'h0 : load_data;
            end
        end
    end

    // Array is never cleared by reset; a store commits on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && a_write && !a_err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: one instance at LATENCY=2 and one at LATENCY=1, each
// driven by the same request tasks and checked against a byte-level memory model.
module tb_mem_req_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst_n;
  logic [1:0]        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0][1:0]   req_size;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0]        resp_valid, resp_ready, resp_err;
  logic [1:0][31:0]  resp_rdata;
  logic [1:0][1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem [2][4096];

  mem_req_ctrl #(.ADDR_W(32), .DEPTH_WORDS(4096), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .dbg_state(dbg_state[0])
  );

  mem_req_ctrl #(.ADDR_W(32), .DEPTH_WORDS(4096), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .dbg_state(dbg_state[1])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Returns {err, rdata}; stores update the reference memory byte by byte.
  function automatic logic [32:0] model_access(input int d, input bit wr, input logic [1:0] size,
                                               input bit uns, input logic [31:0] addr,
                                               input logic [31:0] wdata);
    int nbytes, widx, ln;
    logic [31:0] val;
    if (size == 2'b11 || (size == 2'b10 && addr[0]) || (size == 2'b00 && addr[1:0] != 2'b00)
        || addr >= 32'h4000)
      return {1'b1, 32'h0};
    nbytes = (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
    widx   = int'(addr >> 2);
    ln     = int'(addr & 32'h3);
    if (wr) begin
      for (int b = 0; b < nbytes; b++)
        ref_mem[d][widx][8*(ln+b) +: 8] = wdata[8*b +: 8];
      return {1'b0, 32'h0};
    end
    val = 32'h0;
    for (int b = 0; b < nbytes; b++)
      val[8*b +: 8] = ref_mem[d][widx][8*(ln+b) +: 8];
    if (!uns && nbytes < 4 && val[8*nbytes-1])
      for (int b = nbytes; b < 4; b++) val[8*b +: 8] = 8'hFF;
    return {1'b0, val};
  endfunction

  task automatic drive_accept(input int d, input bit wr, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    check("req_ready_idle", {31'h0, req_ready[d]}, 32'h1);
    req_valid[d]    = 1'b1;
    req_write[d]    = wr;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    @(posedge clk);
    #1;
    req_valid[d]    = 1'b0;
    req_write[d]    = 1'($urandom_range(0, 1));
    req_size[d]     = 2'($urandom_range(0, 3));
    req_unsigned[d] = 1'($urandom_range(0, 1));
    req_addr[d]     = $urandom;
    req_wdata[d]    = $urandom;
  endtask

  task automatic do_req(input int d, input bit wr, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int lat;
    logic [32:0] e;
    drive_accept(d, wr, size, uns, addr, wdata);
    exp_q.push_back(model_access(d, wr, size, uns, addr, wdata));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!resp_valid[d]) check("req_ready_busy", {31'h0, req_ready[d]}, 32'h0);
    end while (!resp_valid[d] && lat < 20);
    check("latency", lat, lat_of(d));
    if (!resp_valid[d]) begin
      void'(exp_q.pop_front());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'h0, resp_valid[d]}, 32'h1);
      check("hold_rdata", resp_rdata[d], exp_q[0][31:0]);
      check("hold_err", {31'h0, resp_err[d]}, {31'h0, exp_q[0][32]});
      check("hold_req_ready", {31'h0, req_ready[d]}, 32'h0);
      @(negedge clk);
    end
    resp_ready[d] = 1'b1;
    e = exp_q.pop_front();
    check("rdata", resp_rdata[d], e[31:0]);
    check("err", {31'h0, resp_err[d]}, {31'h0, e[32]});
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    check("req_ready_after", {31'h0, req_ready[d]}, 32'h1);
    check("resp_valid_after", {31'h0, resp_valid[d]}, 32'h0);
  endtask

  // Reset one cycle after acceptance: mid-WAIT at LATENCY=2, in RESP at LATENCY=1.
  task automatic abort_req(input int d, input logic [31:0] addr, input logic [31:0] wdata);
    drive_accept(d, 1'b1, 2'b00, 1'b0, addr, wdata);
    if (lat_of(d) == 1) void'(model_access(d, 1'b1, 2'b00, 1'b0, addr, wdata));
    @(negedge clk);
    rst_n[d] = 1'b0;
    #1;
    check("req_ready_in_rst", {31'h0, req_ready[d]}, 32'h0);
    @(negedge clk);
    check("rst_resp_valid", {31'h0, resp_valid[d]}, 32'h0);
    check("rst_resp_rdata", resp_rdata[d], 32'h0);
    check("rst_resp_err", {31'h0, resp_err[d]}, 32'h0);
    rst_n[d] = 1'b1;
    #1;
    check("req_ready_post_rst", {31'h0, req_ready[d]}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_resp_after_abort", {31'h0, resp_valid[d]}, 32'h0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 4096; w++) ref_mem[d][w] = 32'h0;
    rst_n = 2'b00; req_valid = '0; req_write = '0; req_unsigned = '0;
    req_size = '0; req_addr = '0; req_wdata = '0; resp_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_req_ready", {31'h0, req_ready[d]}, 32'h0);
      check("reset_resp_valid", {31'h0, resp_valid[d]}, 32'h0);
      check("reset_resp_rdata", resp_rdata[d], 32'h0);
      check("reset_resp_err", {31'h0, resp_err[d]}, 32'h0);
    end
    rst_n = 2'b11;

    // LATENCY=2 instance
    do_req(0, 1, 2'b00, 0, 32'h100, 32'h11223344, 0);
    do_req(0, 0, 2'b00, 0, 32'h100, 32'h0, 0);
    do_req(0, 0, 2'b01, 0, 32'h103, 32'h0, 0);
    do_req(0, 0, 2'b01, 0, 32'h100, 32'h0, 1);
    do_req(0, 1, 2'b01, 0, 32'h101, 32'h00000080, 0);
    do_req(0, 0, 2'b01, 0, 32'h101, 32'h0, 0);
    do_req(0, 0, 2'b01, 1, 32'h101, 32'h0, 0);
    do_req(0, 0, 2'b00, 0, 32'h100, 32'h0, 0);
    do_req(0, 1, 2'b10, 0, 32'h102, 32'h0000BEEF, 0);
    do_req(0, 0, 2'b10, 0, 32'h102, 32'h0, 0);
    do_req(0, 0, 2'b10, 1, 32'h102, 32'h0, 0);
    do_req(0, 0, 2'b00, 1, 32'h100, 32'h0, 0);
    do_req(0, 0, 2'b10, 0, 32'h101, 32'h0, 0);
    do_req(0, 0, 2'b00, 0, 32'h102, 32'h0, 0);
    do_req(0, 0, 2'b11, 0, 32'h100, 32'h0, 0);
    do_req(0, 0, 2'b00, 0, 32'h4000, 32'h0, 0);
    do_req(0, 0, 2'b00, 0, 32'h80000100, 32'h0, 0);
    do_req(0, 1, 2'b00, 0, 32'h102, 32'hDEADBEEF, 0);
    do_req(0, 1, 2'b01, 0, 32'h4000, 32'h000000AA, 0);
    do_req(0, 0, 2'b00, 0, 32'h100, 32'h0, 5);
    do_req(0, 1, 2'b00, 0, 32'h3FFC, 32'hA5A55A5A, 0);
    do_req(0, 0, 2'b01, 0, 32'h3FFF, 32'h0, 0);
    do_req(0, 0, 2'b00, 0, 32'h3FFC, 32'h0, 0);
    do_req(0, 1, 2'b00, 0, 32'h200, 32'h0, 0);
    abort_req(0, 32'h200, 32'hCAFEF00D);
    do_req(0, 0, 2'b00, 0, 32'h200, 32'h0, 0);
    for (int i = 0; i < 20; i++)
      do_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'h100 + 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2));

    // LATENCY=1 instance: the access uses the live request fields
    do_req(1, 1, 2'b00, 0, 32'h100, 32'h11223344, 0);
    do_req(1, 0, 2'b00, 0, 32'h100, 32'h0, 0);
    do_req(1, 0, 2'b10, 1, 32'h102, 32'h0, 2);
    do_req(1, 0, 2'b01, 0, 32'h103, 32'h0, 0);
    do_req(1, 1, 2'b00, 0, 32'h102, 32'hDEADBEEF, 0);
    do_req(1, 0, 2'b00, 0, 32'h100, 32'h0, 0);
    do_req(1, 1, 2'b00, 0, 32'h200, 32'h0, 0);
    abort_req(1, 32'h200, 32'hCAFEF00D);
    do_req(1, 0, 2'b00, 0, 32'h200, 32'h0, 0);
    for (int i = 0; i < 12; i++)
      do_req(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'h100 + 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2));

    check("queue_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
